// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared timing constants, sync window bounds and types for the 640x480@60 Hz
// VGA timing generator and its helpers.
// -----------------------------------------------------------------------------
package vga_pkg;

    // 640x480@60 Hz timing, in pixel ticks (horizontal) and lines (vertical)
    localparam int H_ACTIVE  = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE  = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync pulses are low over the half-open windows [START, END)
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    // 640x480 -> 160x120 scale, and converter latency in pixel ticks (1..4)
    localparam int PIX_SHIFT = 2;
    localparam int COLOR_LAT = 2;

    // Width of the h/v counters
    localparam int CNT_W     = 10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
    } pix_coord_t;

    // Eight vertical colour bars: each bar index bit drives one full channel
    function automatic rgb_t bar_colour(input logic [2:0] bar);
        rgb_t c;
        c.r = {8{bar[2]}};
        c.g = {8{bar[1]}};
        c.b = {8{bar[0]}};
        return c;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// -----------------------------------------------------------------------------
// vga_delay_line
// Enable-gated shift register used to align sync/blank with the converter's
// colour latency. All stages reset to RESET_VAL.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : shift enable (one pixel tick)
//   din        : value entering stage 0
//   dout       : value leaving the last stage (DEPTH ticks old)
// -----------------------------------------------------------------------------
module vga_delay_line #(
    parameter int                WIDTH     = 1,
    parameter int                DEPTH     = 2,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_r;

    // Shift one stage per enabled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= RESET_VAL;
            end
        end else if (en) begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// 640x480@60 Hz VGA timing from CLOCK_50 (one pixel tick every other cycle).
// Publishes a 160x120 coordinate with a one-cycle request to the board-to-pixel
// converter, takes its colour CFG_COLOR_LAT ticks later, and drives the DAC with
// sync and blank delayed by the same amount.
//   CLOCK_50, KEY     : 50 MHz clock, asynchronous active-low reset
//   pix_x, pix_y      : scaled coordinate (held outside the visible area)
//   pix_req           : one-cycle pulse per visible pixel tick
//   pix_colour        : {R,G,B} answer from the converter
//   frame_start       : one-cycle pulse on the tick at h=0, v=0 (not delayed)
//   VGA_*             : DAC colour, syncs, blank, sync-on-green (held 0), clock
// Build option: define VGA_TEST_PATTERN_EN to ignore pix_colour and show eight
// colour bars derived from the delayed pix_x[7:5].
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CFG_H_ACTIVE  = H_ACTIVE,
    parameter int CFG_H_FP      = H_FP,
    parameter int CFG_H_SYNC    = H_SYNC,
    parameter int CFG_H_BP      = H_BP,
    parameter int CFG_V_ACTIVE  = V_ACTIVE,
    parameter int CFG_V_FP      = V_FP,
    parameter int CFG_V_SYNC    = V_SYNC,
    parameter int CFG_V_BP      = V_BP,
    parameter int CFG_PIX_SHIFT = PIX_SHIFT,
    parameter int CFG_COLOR_LAT = COLOR_LAT
) (
    input  logic        CLOCK_50,
    input  logic        KEY,
    output logic [7:0]  pix_x,
    output logic [6:0]  pix_y,
    output logic        pix_req,
    input  logic [23:0] pix_colour,
    output logic        frame_start,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        VGA_CLK
);

    localparam int H_TOT = CFG_H_ACTIVE + CFG_H_FP + CFG_H_SYNC + CFG_H_BP;
    localparam int V_TOT = CFG_V_ACTIVE + CFG_V_FP + CFG_V_SYNC + CFG_V_BP;

    localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(CFG_H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(CFG_V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(CFG_H_ACTIVE + CFG_H_FP);
    localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(CFG_H_ACTIVE + CFG_H_FP + CFG_H_SYNC);
    localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(CFG_V_ACTIVE + CFG_V_FP);
    localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(CFG_V_ACTIVE + CFG_V_FP + CFG_V_SYNC);

    // Delay-line payload: {[bar index,] hs, vs, active}; idle value is syncs high, blank
`ifdef VGA_TEST_PATTERN_EN
    localparam int               DLY_W   = 6;
    localparam logic [DLY_W-1:0] DLY_RST = 6'b000_1_1_0;
`else
    localparam int               DLY_W   = 3;
    localparam logic [DLY_W-1:0] DLY_RST = 3'b1_1_0;
`endif

    logic             rst_n_s;
    logic             pix_en_r;
    logic             vga_clk_r;
    logic [CNT_W-1:0] h_cnt_r;
    logic [CNT_W-1:0] v_cnt_r;
    logic             active_s;
    logic             hs_raw_s;
    logic             vs_raw_s;
    pix_coord_t       coord_s;
    pix_coord_t       coord_r;
    logic             pix_req_r;
    logic             frame_start_r;
    logic [DLY_W-1:0] dly_in_s;
    logic [DLY_W-1:0] dly_out_s;
    logic             dly_active_s;
    logic             dly_hs_s;
    logic             dly_vs_s;
    rgb_t             colour_s;
    rgb_t             rgb_r;
    logic             hs_r;
    logic             vs_r;
    logic             blank_n_r;

    assign rst_n_s = KEY;

    // Pixel tick enable and the registered 25 MHz DAC clock (high the cycle after a tick)
    always_ff @(posedge CLOCK_50 or negedge rst_n_s) begin
        if (!rst_n_s) begin
            pix_en_r  <= 1'b0;
            vga_clk_r <= 1'b0;
        end else begin
            pix_en_r  <= ~pix_en_r;
            vga_clk_r <= pix_en_r;
        end
    end

    // Horizontal and vertical position counters, advancing once per pixel tick
    always_ff @(posedge CLOCK_50 or negedge rst_n_s) begin
        if (!rst_n_s) begin
            h_cnt_r <= '0;
            v_cnt_r <= '0;
        end else if (pix_en_r) begin
            if (h_cnt_r == H_LAST_C) begin
                h_cnt_r <= '0;
                if (v_cnt_r == V_LAST_C) begin
                    v_cnt_r <= '0;
                end else begin
                    v_cnt_r <= v_cnt_r + 10'd1;
                end
            end else begin
                h_cnt_r <= h_cnt_r + 10'd1;
            end
        end
    end

    // Decode visible area, sync windows and the truncated 160x120 coordinate
    always_comb begin
        active_s  = (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
        hs_raw_s  = !((h_cnt_r >= HS_START_C) && (h_cnt_r < HS_END_C));
        vs_raw_s  = !((v_cnt_r >= VS_START_C) && (v_cnt_r < VS_END_C));
        coord_s.x = 8'(h_cnt_r >> CFG_PIX_SHIFT);
        coord_s.y = 7'(v_cnt_r >> CFG_PIX_SHIFT);
    end

    // Request stage: coordinate only updates on visible ticks, pulses last one cycle
    always_ff @(posedge CLOCK_50 or negedge rst_n_s) begin
        if (!rst_n_s) begin
            pix_req_r     <= 1'b0;
            frame_start_r <= 1'b0;
            coord_r       <= '0;
        end else begin
            pix_req_r     <= active_s && pix_en_r;
            frame_start_r <= pix_en_r && (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
            if (pix_en_r && active_s) begin
                coord_r <= coord_s;
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] dly_bar_s;
    assign dly_in_s = {coord_s.x[7:5], hs_raw_s, vs_raw_s, active_s};
    assign {dly_bar_s, dly_hs_s, dly_vs_s, dly_active_s} = dly_out_s;
`else
    assign dly_in_s = {hs_raw_s, vs_raw_s, active_s};
    assign {dly_hs_s, dly_vs_s, dly_active_s} = dly_out_s;
`endif

    vga_delay_line #(
        .WIDTH     (DLY_W),
        .DEPTH     (CFG_COLOR_LAT),
        .RESET_VAL (DLY_RST)
    ) u_align (
        .clk   (CLOCK_50),
        .rst_n (rst_n_s),
        .en    (pix_en_r),
        .din   (dly_in_s),
        .dout  (dly_out_s)
    );

    // Select the colour source feeding the DAC stage
    always_comb begin
        colour_s = '0;
`ifdef VGA_TEST_PATTERN_EN
        colour_s = bar_colour(dly_bar_s);
`else
        colour_s = rgb_t'(pix_colour);
`endif
    end

    // DAC stage: capture colour on visible delayed ticks, force black while blanked
    always_ff @(posedge CLOCK_50 or negedge rst_n_s) begin
        if (!rst_n_s) begin
            rgb_r     <= '0;
            hs_r      <= 1'b1;
            vs_r      <= 1'b1;
            blank_n_r <= 1'b0;
        end else if (pix_en_r) begin
            hs_r      <= dly_hs_s;
            vs_r      <= dly_vs_s;
            blank_n_r <= dly_active_s;
            rgb_r     <= dly_active_s ? colour_s : rgb_t'(24'h000000);
        end
    end

    assign pix_x       = coord_r.x;
    assign pix_y       = coord_r.y;
    assign pix_req     = pix_req_r;
    assign frame_start = frame_start_r;
    assign VGA_R       = rgb_r.r;
    assign VGA_G       = rgb_r.g;
    assign VGA_B       = rgb_r.b;
    assign VGA_HS      = hs_r;
    assign VGA_VS      = vs_r;
    assign VGA_BLANK_N = blank_n_r;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = vga_clk_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Self-checking bench for vga_timing_gen. Full horizontal timing, shortened
// vertical timing (16 visible lines of 24) so a whole frame plus a mid-frame
// reset fits in a short run. Expected outputs come from an arithmetic model
// indexed by absolute pixel-tick number since reset release.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int LAT = 2;
    localparam int HA = 640, HFP = 16, HSW = 96, HBP = 48;
    localparam int VA = 16,  VFP = 3,  VSW = 2,  VBP = 3;
    localparam int HT = HA + HFP + HSW + HBP;   // 800
    localparam int VT = VA + VFP + VSW + VBP;   // 24
    localparam int FT = HT * VT;                // ticks per frame

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] pix_colour = 24'h000000;
    logic [7:0]  pix_x;
    logic [6:0]  pix_y;
    logic        pix_req, frame_start;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;

    vga_timing_gen #(
        .CFG_H_ACTIVE(HA), .CFG_H_FP(HFP), .CFG_H_SYNC(HSW), .CFG_H_BP(HBP),
        .CFG_V_ACTIVE(VA), .CFG_V_FP(VFP), .CFG_V_SYNC(VSW), .CFG_V_BP(VBP),
        .CFG_PIX_SHIFT(2), .CFG_COLOR_LAT(LAT)
    ) dut (
        .CLOCK_50(clk), .KEY(rst_n),
        .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req), .pix_colour(pix_colour),
        .frame_start(frame_start),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: m = clock edges since reset release
    int          m;
    logic        exp_req, exp_fs, exp_hs, exp_vs, exp_blank, exp_vclk;
    logic [7:0]  exp_x;
    logic [6:0]  exp_y;
    logic [23:0] exp_rgb;

    // First-frame statistics gathered from the DUT
    bit first_pass = 1'b0;
    int st_req = 0, st_fs = 0, st_req_blank_line = 0, st_hs_low = 0, st_vs_low = 0;

    function automatic int h_of(input int n); return n % HT; endfunction
    function automatic int v_of(input int n); return (n / HT) % VT; endfunction
    function automatic bit act(input int n);
        return (h_of(n) < HA) && (v_of(n) < VA);
    endfunction

    function automatic logic [23:0] colour_for(input int k);
`ifdef VGA_TEST_PATTERN_EN
        int bar;
        bar = (h_of(k) / 4) / 32;
        return {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
`else
        return pix_colour;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, want, m);
        end
    endtask

    task automatic reset_model;
        m = 0;
        exp_req = 1'b0; exp_fs = 1'b0; exp_x = 8'd0; exp_y = 7'd0;
        exp_hs = 1'b1; exp_vs = 1'b1; exp_blank = 1'b0; exp_rgb = 24'h000000;
        exp_vclk = 1'b0;
    endtask

    // Advance model to the state after edge m
    task automatic model_edge;
        int n, k;
        exp_vclk = (m % 2 == 0);
        if (m % 2 == 0) begin
            n = m / 2 - 1;
            exp_req = act(n);
            exp_fs  = (n % FT == 0);
            if (act(n)) begin
                exp_x = 8'(h_of(n) / 4);
                exp_y = 7'(v_of(n) / 4);
            end
            if (n >= LAT) begin
                k = n - LAT;
                exp_hs    = !(h_of(k) >= HA + HFP && h_of(k) < HA + HFP + HSW);
                exp_vs    = !(v_of(k) >= VA + VFP && v_of(k) < VA + VFP + VSW);
                exp_blank = act(k);
                exp_rgb   = act(k) ? colour_for(k) : 24'h000000;
            end
        end else begin
            exp_req = 1'b0;
            exp_fs  = 1'b0;
        end
    endtask

    task automatic compare_all;
        chk("pix_req", pix_req, exp_req);
        chk("frame_start", frame_start, exp_fs);
        chk("pix_x", pix_x, exp_x);
        chk("pix_y", pix_y, exp_y);
        chk("vga_hs", VGA_HS, exp_hs);
        chk("vga_vs", VGA_VS, exp_vs);
        chk("vga_blank_n", VGA_BLANK_N, exp_blank);
        chk("vga_rgb", {VGA_R, VGA_G, VGA_B}, exp_rgb);
        chk("vga_sync_n", VGA_SYNC_N, 1'b0);
        chk("vga_clk", VGA_CLK, exp_vclk);
    endtask

    // Hand-computed anchors and first-frame statistics
    task automatic pins_and_stats;
        int n;
        if (m % 2 == 0) begin
            n = m / 2 - 1;
            if (n == 0) begin
                chk("fs_first_tick", frame_start, 1'b1);
                chk("x_h0", pix_x, 8'd0);
            end
            if (n == 3)            chk("x_h3", pix_x, 8'd0);
            if (n == 4)            chk("x_h4", pix_x, 8'd1);
            if (n == 15 * HT + 5)  chk("y_last_vis_line", pix_y, 7'd3);
            if (n == 657)          chk("hs_before_window", VGA_HS, 1'b1);
            if (n == 658)          chk("hs_first_low", VGA_HS, 1'b0);
            if (n == 641)          chk("blank_last_vis", VGA_BLANK_N, 1'b1);
            if (n == 642)          chk("blank_porch", VGA_BLANK_N, 1'b0);
`ifdef VGA_TEST_PATTERN_EN
            if (n == 128 + LAT)    chk("bar_x32", {VGA_R, VGA_G, VGA_B}, 24'h0000FF);
            if (n == 512 + LAT)    chk("bar_x128", {VGA_R, VGA_G, VGA_B}, 24'hFF0000);
`else
            if (n == 41)           chk("r_x9", VGA_R, 8'h00);
            if (n == 42)           chk("r_x10", VGA_R, 8'hFF);
            if (n == 46)           chk("r_x11", VGA_R, 8'h00);
            if (n == HT + 641)     chk("rgb_white_vis", {VGA_R, VGA_G, VGA_B}, 24'hFFFFFF);
            if (n == HT + 642)     chk("rgb_white_blank", {VGA_R, VGA_G, VGA_B}, 24'h000000);
`endif
            if (first_pass) begin
                if (n < FT) begin
                    st_req += int'(pix_req);
                    st_fs  += int'(frame_start);
                    if (n / HT == VA) st_req_blank_line += int'(pix_req);
                end
                if (n >= LAT && n < FT + LAT) begin
                    st_hs_low += int'(!VGA_HS);
                    st_vs_low += int'(!VGA_VS);
                end
            end
        end
    endtask

    // Converter stand-in: line 0 answers only x=10 in red, line 1 is all white,
    // later lines are random
    task automatic drive_next;
        int nn, k;
        if ((m + 1) % 2 == 0) begin
            nn = (m + 1) / 2 - 1;
            k  = nn - LAT;
            if (nn / HT == 0) begin
                pix_colour = (k >= 0 && act(k) && (h_of(k) / 4) == 10) ? 24'hFF0000 : 24'h000000;
            end else if (nn / HT == 1) begin
                pix_colour = 24'hFFFFFF;
            end else begin
                pix_colour = 24'($urandom);
            end
        end
    endtask

    task automatic step;
        @(posedge clk);
        m++;
        model_edge();
        @(negedge clk);
        compare_all();
        pins_and_stats();
        drive_next();
    endtask

    initial begin
        reset_model();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        first_pass = 1'b1;
        repeat (2 * (FT + LAT + 10)) step();
        first_pass = 1'b0;

        chk("frame_start_count", st_fs, 1);
        chk("pix_req_count", st_req, HA * VA);
        chk("pix_req_first_blank_line", st_req_blank_line, 0);
        chk("hs_low_ticks", st_hs_low, HSW * VT);
        chk("vs_low_ticks", st_vs_low, VSW * HT);

        // Run into the second frame up to h=300, v=10, then reset mid-frame
        while (m < 2 * (FT + 10 * HT + 300)) step();
        rst_n = 1'b0;
        #1;
        reset_model();
        compare_all();
        repeat (3) begin
            @(negedge clk);
            compare_all();
        end
        rst_n = 1'b1;
        repeat (4 * HT) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
